day11_count_source: RTL and testbench

Stream transmitter that drives the day-11 count-stream interface, the producer end of the link consumed by the day-11 accumulator. A host fills an internal buffer with 64-bit path counts, then pulses `start`. The block issues a one-cycle `sink_load` to re-arm the consumer, then streams the stored counts in write order with valid/last framing under `ready` backpressure. The buffer is retained after a transfer, so the same set can be replayed.

---
 rtl/day11_count_source_if.sv | 30 +++
 rtl/day11_count_source.sv | 65 ++++++
 tb/tb_day11_count_source.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/day11_count_source_if.sv
// day11_count_source_if: host write port plus the count-stream link to the day-11 accumulator.
interface day11_count_source_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_full;
    logic             flush;
    logic             start;
    logic [CW-1:0]    entries;
    logic             busy;
    logic             sent;
    logic             sink_load;
    logic [WIDTH-1:0] count;
    logic             count_valid;
    logic             count_last;
    logic             ready;

    modport slave (
        input  wr_valid, wr_data, flush, start, ready,
        output wr_full, entries, busy, sent, sink_load, count, count_valid, count_last
    );

    modport master (
        output wr_valid, wr_data, flush, start, ready,
        input  wr_full, entries, busy, sent, sink_load, count, count_valid, count_last
    );
endinterface

// File: rtl/day11_count_source.sv
// day11_count_source: buffers host-written counts and replays them as a framed
// valid/last stream after a one-cycle sink_load to re-arm the consumer.
module day11_count_source #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic clock,
    input logic clear,
    day11_count_source_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [CW-1:0]    r_entries, r_idx, w_entries_nx;
    logic             r_sent, w_idle, w_wr_acc, w_start_acc, w_accept, w_last;

    assign w_idle       = r_state == IDLE;
    assign w_wr_acc     = w_idle & bus.wr_valid & ~bus.wr_full & ~bus.flush;
    assign w_entries_nx = (w_idle & bus.flush) ? '0 : r_entries + CW'(w_wr_acc);
    // A same-cycle write counts toward the length test, so write+start on an empty buffer streams it
    assign w_start_acc  = w_idle & bus.start & ~bus.flush & (w_entries_nx != '0);
    assign w_accept     = (r_state == SEND) & bus.ready;
    assign w_last       = r_idx == r_entries - CW'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= IDLE;
            r_entries <= '0;
            r_idx     <= '0;
            r_sent    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_entries <= w_entries_nx;
            r_idx     <= (r_state == LOAD) ? '0 : w_accept ? r_idx + CW'(1) : r_idx;
            r_sent    <= w_accept & w_last;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_acc)
            r_buf[r_entries[AW-1:0]] <= bus.wr_data;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_start_acc ? LOAD : IDLE) :
                 (r_state == LOAD) ? SEND :
                 (r_state == SEND) ? ((w_accept & w_last) ? IDLE : SEND) : IDLE;
    end

    // Stream outputs depend on registered state only, never on ready
    always_comb begin
        bus.wr_full     = r_entries == CW'(DEPTH);
        bus.entries     = r_entries;
        bus.busy        = ~w_idle;
        bus.sent        = r_sent;
        bus.sink_load   = r_state == LOAD;
        bus.count_valid = r_state == SEND;
        bus.count_last  = (r_state == SEND) & w_last;
        bus.count       = (r_state == SEND) ? r_buf[r_idx[AW-1:0]] : '0;
    end
endmodule

// File: tb/tb_day11_count_source.sv
// tb_day11_count_source: cycle table for stream/backpressure/replay plus directed corner sequences.
module tb_day11_count_source;
    logic clock = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    int   n_last, n_load;
    logic done;
    logic [63:0] got_q[$];

    typedef struct {
        logic        wv;
        logic [63:0] wd;
        logic        fl;
        logic        st;
        logic        rdy;
        logic [73:0] exp;
    } vec_t;
    vec_t tbl[$];

    day11_count_source_if #(.WIDTH(64), .DEPTH(8)) b();
    day11_count_source #(.WIDTH(64), .DEPTH(8)) dut (.clock(clock), .clear(clear), .bus(b));

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1);
    end

    function automatic logic [73:0] pk();
        return {b.entries, b.busy, b.sink_load, b.count_valid, b.count_last, b.sent, b.wr_full, b.count};
    endfunction

    function automatic void add(logic wv, logic [63:0] wd, logic fl, logic st, logic rdy,
                                logic [3:0] e, logic bs, logic ld, logic vl, logic ls,
                                logic sn, logic fu, logic [63:0] c);
        tbl.push_back('{wv, wd, fl, st, rdy, {e, bs, ld, vl, ls, sn, fu, c}});
    endfunction

    task automatic chk(input string nm, input logic [73:0] got, input logic [73:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic rst();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic wr(input logic [63:0] d);
        b.wr_valid = 1'b1;
        b.wr_data  = d;
        @(negedge clock);
        b.wr_valid = 1'b0;
    endtask

    task automatic xfer(input logic wv, input logic [63:0] wd);
        got_q.delete();
        n_last = 0;
        n_load = 0;
        done   = 1'b0;
        b.start = 1'b1; b.ready = 1'b1; b.wr_valid = wv; b.wr_data = wd;
        @(negedge clock);
        b.start = 1'b0; b.wr_valid = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (b.sink_load) n_load++;
            if (b.count_valid) begin
                got_q.push_back(b.count);
                if (b.count_last) n_last++;
            end
            if (b.sent) done = 1'b1;
            else @(negedge clock);
        end
        chk("xfer_done", 74'(done), 74'(1));
    endtask

    initial begin
        b.wr_valid = 0; b.wr_data = 0; b.flush = 0; b.start = 0; b.ready = 0;
        //  wv  wd  fl st rdy | ent bsy ld vl ls sn fu count
        add(1,  3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        add(1,  5, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        add(1,  7, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        add(1, 11, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0);
        add(1, 13, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0);
        add(1, 17, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0, 0);
        add(1, 19, 0, 0, 1,   6, 0, 0, 0, 0, 0, 0, 0);
        add(0,  0, 0, 1, 1,   7, 0, 0, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0, 1,   7, 1, 1, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 3);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 5);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 7);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 11);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 13);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 17);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 1, 0, 0, 19);
        add(0,  0, 0, 1, 1,   7, 0, 0, 0, 0, 1, 0, 0);
        add(0,  0, 0, 0, 0,   7, 1, 1, 0, 0, 0, 0, 0);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 3);
        add(1, 99, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 5);
        add(0,  0, 1, 0, 0,   7, 1, 0, 1, 0, 0, 0, 5);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 5);
        add(0,  0, 0, 1, 0,   7, 1, 0, 1, 0, 0, 0, 7);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 7);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 7);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 11);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 11);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 11);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 13);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 13);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 13);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 17);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 0, 0, 0, 17);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 0, 0, 0, 17);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 1, 0, 0, 19);
        add(0,  0, 0, 0, 0,   7, 1, 0, 1, 1, 0, 0, 19);
        add(0,  0, 0, 0, 1,   7, 1, 0, 1, 1, 0, 0, 19);
        add(0,  0, 0, 0, 0,   7, 0, 0, 0, 0, 1, 0, 0);
        add(0,  0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0, 0);

        rst();
        foreach (tbl[i]) begin
            chk($sformatf("row%0d", i), pk(), tbl[i].exp);
            b.wr_valid = tbl[i].wv; b.wr_data = tbl[i].wd; b.flush = tbl[i].fl;
            b.start = tbl[i].st; b.ready = tbl[i].rdy;
            @(negedge clock);
        end
        b.wr_valid = 0; b.flush = 0; b.start = 0;

        // Fill to capacity, overflow write dropped, stream and replay
        rst();
        for (int i = 0; i < 9; i++) wr(64'(10 + i));
        chk("full", 74'({b.wr_full, b.entries}), 74'({1'b1, 4'd8}));
        for (int r = 0; r < 2; r++) begin
            xfer(1'b0, 64'd0);
            chk($sformatf("full_len%0d", r), 74'(got_q.size()), 74'(8));
            for (int i = 0; i < 8; i++)
                if (i < got_q.size()) chk($sformatf("full_beat%0d_%0d", r, i), 74'(got_q[i]), 74'(10 + i));
            chk($sformatf("full_ctl%0d", r), 74'({n_last[7:0], n_load[7:0]}), 74'({8'd1, 8'd1}));
        end

        // Start on empty buffer ignored; write+start streams the written value
        rst();
        b.start = 1'b1;
        @(negedge clock);
        b.start = 1'b0;
        n_load = 0;
        done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (b.sink_load) n_load++;
            done = done | b.busy;
            @(negedge clock);
        end
        chk("empty_start", 74'({n_load[7:0], done}), 74'(0));
        xfer(1'b1, 64'd42);
        chk("ws_len", 74'(got_q.size()), 74'(1));
        if (got_q.size() > 0) chk("ws_beat", 74'(got_q[0]), 74'(42));
        chk("ws_ctl", 74'({n_last[7:0], n_load[7:0]}), 74'({8'd1, 8'd1}));

        // Clear during the third beat aborts without a sent pulse
        rst();
        for (int i = 1; i <= 5; i++) wr(64'(i));
        b.start = 1'b1; b.ready = 1'b1;
        @(negedge clock);
        b.start = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (b.count_valid && b.count == 64'd3) done = 1'b1;
            else @(negedge clock);
        end
        chk("clr_reach3", 74'(done), 74'(1));
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clr_outs", pk(), 74'(0));
        done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            done = done | b.sent | b.busy;
            @(negedge clock);
        end
        chk("clr_quiet", 74'(done), 74'(0));
        xfer(1'b1, 64'd7);
        chk("clr_after", 74'({got_q.size() == 1, got_q.size() > 0 ? got_q[0] : 64'd0}), 74'({1'b1, 64'd7}));

        // Flush with start in the same cycle empties the buffer and starts nothing
        rst();
        for (int i = 0; i < 4; i++) wr(64'(100 + i));
        chk("fl_ent4", 74'(b.entries), 74'(4));
        b.flush = 1'b1; b.start = 1'b1;
        @(negedge clock);
        b.flush = 1'b0; b.start = 1'b0;
        chk("fl_t1", pk(), 74'(0));
        @(negedge clock);
        chk("fl_t2", pk(), 74'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
